// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with valid/ready flow control, 1-entry skid buffer and flush.
// Define ID_EX_STATS_EN to add saturating stall/bubble counters (stall_cnt_o, bubble_cnt_o).
module id_ex_stage #(
  parameter int IW = 32,
  parameter int DW = 32,
  parameter int CW = 7
`ifdef ID_EX_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IW-1:0]    inst_i,
  input  logic [DW-1:0]    data1_i,
  input  logic [DW-1:0]    data2_i,
  input  logic [DW-1:0]    sign_ext_i,
  input  logic [CW-1:0]    ctrl_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IW-1:0]    inst_o,
  output logic [DW-1:0]    data1_o,
  output logic [DW-1:0]    data2_o,
  output logic [DW-1:0]    sign_ext_o,
  output logic [CW-1:0]    ctrl_o,
`ifdef ID_EX_STATS_EN
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
`endif
  output logic [1:0]       state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready_o depends only on registered state; out_valid_o never depends on out_ready_i.

  // Encoding is {main_valid, skid_valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b10,
    SKID  = 2'b11
  } state_t;

  typedef struct packed {
    logic [IW-1:0] inst;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;
    logic [DW-1:0] sext;
    logic [CW-1:0] ctrl;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q, in_entry;
  logic   main_valid, skid_valid;
  logic   in_xfer, out_xfer;
  logic   load_main, load_skid, skid_to_main;

  assign main_valid = state_q[1];
  assign skid_valid = state_q[0];
  assign in_ready_o = !skid_valid;
  assign in_xfer    = in_valid_i && in_ready_o;
  assign out_xfer   = main_valid && out_ready_i;
  assign state_o    = state_q;

  assign in_entry = '{inst: inst_i, data1: data1_i, data2: data2_i,
                      sext: sign_ext_i, ctrl: ctrl_i};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d   = FULL;
          load_main = 1'b1;
        end
      end
      FULL: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          state_d   = SKID;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        if (out_xfer) begin
          state_d      = FULL;
          skid_to_main = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops everything held plus whatever is presented this cycle.
    if (flush_i) begin
      state_d      = EMPTY;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= in_entry;
      end else if (skid_to_main) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  assign out_valid_o = main_valid;
  assign inst_o      = main_q.inst;
  assign data1_o     = main_q.data1;
  assign data2_o     = main_q.data2;
  assign sign_ext_o  = main_q.sext;
  // Stale payload may linger after flush; gating ctrl keeps EX free of side effects.
  assign ctrl_o      = main_valid ? main_q.ctrl : '0;

`ifdef ID_EX_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (main_valid && !out_ready_i && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (!main_valid && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed reset/stream/backpressure/flush cases,
// a random flow-control run against an expected-entry queue, and counters when enabled.
module tb_id_ex_stage;

  localparam int IW = 32;
  localparam int DW = 32;
  localparam int CW = 7;
  localparam int EW = IW + 3*DW + CW;
`ifdef ID_EX_STATS_EN
  localparam int CNT_W = 4;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [IW-1:0] inst_i;
  logic [DW-1:0] data1_i, data2_i, sign_ext_i;
  logic [CW-1:0] ctrl_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [IW-1:0] inst_o;
  logic [DW-1:0] data1_o, data2_o, sign_ext_o;
  logic [CW-1:0] ctrl_o;
  logic [1:0]    state_o;
`ifdef ID_EX_STATS_EN
  logic [CNT_W-1:0] stall_cnt_o, bubble_cnt_o;
`endif

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  id_ex_stage #(
    .IW(IW), .DW(DW), .CW(CW)
`ifdef ID_EX_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .inst_i      (inst_i),
    .data1_i     (data1_i),
    .data2_i     (data2_i),
    .sign_ext_i  (sign_ext_i),
    .ctrl_i      (ctrl_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .inst_o      (inst_o),
    .data1_o     (data1_o),
    .data2_o     (data2_o),
    .sign_ext_o  (sign_ext_o),
    .ctrl_o      (ctrl_o),
`ifdef ID_EX_STATS_EN
    .stall_cnt_o (stall_cnt_o),
    .bubble_cnt_o(bubble_cnt_o),
`endif
    .state_o     (state_o)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [IW-1:0] inst, input logic [CW-1:0] ctrl);
    in_valid_i = v;
    inst_i     = inst;
    data1_i    = $urandom;
    data2_i    = $urandom;
    sign_ext_i = $urandom;
    ctrl_i     = ctrl;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0);
  endtask

  // ---------------- scoreboard ----------------
  // Inputs settle 1 time unit after posedge, so the negedge sees what the next edge will use.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) check("sb_unexpected_out", {IW'(0), inst_o}, '1);
        else check("sb_payload", {inst_o, data1_o, data2_o, sign_ext_o, ctrl_o}, exp_q.pop_front());
      end
      if (!out_valid_o) check("ctrl_gate_idle", ctrl_o, '0);
      if (flush_i) exp_q.delete();
      else if (in_valid_i && in_ready_o)
        exp_q.push_back({inst_i, data1_i, data2_i, sign_ext_i, ctrl_i});
    end
  end

  // ---------------- stimulus ----------------
  logic [IW-1:0] inst_a;
  logic [DW-1:0] data1_a;

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    idle();

    // Reset
    step(); step();
    check("rst_out_valid", out_valid_o, 0);
    check("rst_ctrl", ctrl_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_state", state_o, 2'b00);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", in_ready_o, 1);

    // Streaming with 1-cycle latency and no bubbles
    out_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h1000_0000 + IW'(k), CW'(k + 1));
      step();
      check("stream_valid", out_valid_o, 1);
      check("stream_inst", inst_o, 32'h1000_0000 + IW'(k));
      check("stream_ctrl", ctrl_o, CW'(k + 1));
    end
    idle();
    step();
    check("stream_end_valid", out_valid_o, 0);
    check("stream_end_ctrl", ctrl_o, 0);

    // Backpressure into skid, then release
    out_ready_i = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 7'h11);
    inst_a  = inst_i;
    data1_a = data1_i;
    step();
    check("bp_a_valid", out_valid_o, 1);
    check("bp_a_inst", inst_o, inst_a);
    drive(1'b1, 32'hBBBB_0002, 7'h22);
    step();
    check("bp_skid_ready", in_ready_o, 0);
    check("bp_skid_state", state_o, 2'b11);
    check("bp_skid_inst", inst_o, inst_a);
    drive(1'b1, 32'hDEAD_0000, 7'h33);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_inst", inst_o, inst_a);
      check("bp_hold_data1", data1_o, data1_a);
      check("bp_hold_ready", in_ready_o, 0);
    end
    idle();
    out_ready_i = 1'b1;
    step();
    check("bp_b_inst", inst_o, 32'hBBBB_0002);
    check("bp_b_state", state_o, 2'b10);
    step();
    check("bp_drain_valid", out_valid_o, 0);
    check("bp_drain_queue", exp_q.size(), 0);

    // Flush while in SKID with a new entry presented
    out_ready_i = 1'b0;
    drive(1'b1, 32'hA200_0000, 7'h01); step();
    drive(1'b1, 32'hB200_0000, 7'h02); step();
    check("fl_pre_state", state_o, 2'b11);
    drive(1'b1, 32'hC000_0000, 7'h7F);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    idle();
    check("fl_skid_valid", out_valid_o, 0);
    check("fl_skid_ctrl", ctrl_o, 0);
    check("fl_skid_ready", in_ready_o, 1);

    // Flushed entry with all control bits set must not leak
    drive(1'b1, 32'hE000_0000, 7'h7F);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    idle();
    check("fl_gate_valid", out_valid_o, 0);
    check("fl_gate_ctrl", ctrl_o, 0);
    step();
    check("fl_gate_ctrl_hold", ctrl_o, 0);

    // Next entry passes normally
    out_ready_i = 1'b1;
    drive(1'b1, 32'hD000_0000, 7'h55);
    step();
    idle();
    check("fl_d_inst", inst_o, 32'hD000_0000);
    check("fl_d_ctrl", ctrl_o, 7'h55);
    step();
    check("fl_d_done", out_valid_o, 0);

    // Reset while in SKID
    out_ready_i = 1'b0;
    drive(1'b1, 32'h5000_0001, 7'h0F); step();
    drive(1'b1, 32'h5000_0002, 7'h0F); step();
    idle();
    rst_n = 1'b0;
    step();
    check("rst_skid_valid", out_valid_o, 0);
    check("rst_skid_ready", in_ready_o, 1);
    check("rst_skid_inst", inst_o, 0);
    rst_n = 1'b1;
    step();

    // Random flow control, occasional flush
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, CW'($urandom));
      out_ready_i = $urandom_range(0, 2) != 0;
      flush_i     = $urandom_range(0, 15) == 0;
      step();
    end
    idle();
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    repeat (4) step();
    check("rand_drain_queue", exp_q.size(), 0);
    check("rand_drain_valid", out_valid_o, 0);

`ifdef ID_EX_STATS_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("stats_rst_stall", stall_cnt_o, 0);
    check("stats_rst_bubble", bubble_cnt_o, 0);
    out_ready_i = 1'b0;
    drive(1'b1, 32'h7000_0000, 7'h01);
    step();
    idle();
    repeat (20) step();
    check("stats_stall_sat", stall_cnt_o, 4'hF);
    out_ready_i = 1'b1;
    repeat (20) step();
    check("stats_bubble_sat", bubble_cnt_o, 4'hF);
    check("stats_stall_kept", stall_cnt_o, 4'hF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
